// File: rtl/emern_scan_timing.sv
// VGA scan-timing generator: free-running row/column counters, sync and blank
// terms delayed to match the pixel core, plus the vertical-blank command window.
module emern_scan_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] row_counter,
   output logic [9:0] col_counter,
   output logic       h_sync,
   output logic       v_sync,
   output logic       screen_inactive,
   output logic       cmd_en,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] col_next;
   logic [9:0] row_next;
   logic       col_wrap;
   logic       frame_wrap;
   logic [2:0] raw;
   logic [2:0] pipe [PIPE_DELAY];

   always_comb begin
      col_wrap   = (col_counter == H_LAST);
      frame_wrap = col_wrap && (row_counter == V_LAST);
      col_next   = col_wrap ? '0 : col_counter + 10'd1;
      row_next   = row_counter;
      if (col_wrap) begin
         row_next = (row_counter == V_LAST) ? '0 : row_counter + 10'd1;
      end
   end

   // Bit order in each stage: {hs, vs, blank}
   always_comb begin
      raw[2] = !((col_counter >= HS_START) && (col_counter < HS_END));
      raw[1] = !((row_counter >= VS_START) && (row_counter < VS_END));
      raw[0] = (col_counter >= H_VIS) || (row_counter >= V_VIS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_counter <= '0;
         row_counter <= '0;
         cmd_en      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         col_counter <= col_next;
         row_counter <= row_next;
         // Registered from next-state values so both stay aligned with the counters
         cmd_en      <= (row_next >= V_VIS);
         frame_start <= frame_wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PIPE_DELAY; i++) pipe[i] <= '1;
      end else begin
         pipe[0] <= raw;
         for (int unsigned i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign h_sync          = pipe[PIPE_DELAY-1][2];
   assign v_sync          = pipe[PIPE_DELAY-1][1];
   assign screen_inactive = pipe[PIPE_DELAY-1][0];

endmodule

// File: tb/tb_emern_scan_timing.sv
// Scoreboard bench: stimulus queues hand-computed (tick, signal, value) entries,
// a negedge monitor compares whichever entries fall due on the current tick.
module tb_emern_scan_timing;

   localparam int D1 = 0, D3 = 1, S1 = 2, S3 = 3;
   localparam int ROW = 0, COL = 1, HS = 2, VS = 3, SCR = 4, CMD = 5, FS = 6;

   typedef struct {
      int t;
      int inst;
      int sig;
      int exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         tick = 0;
   int         base = 0;
   int         checks = 0;
   int         passed = 0;
   exp_t       sb [$];

   logic [9:0] row [4];
   logic [9:0] col [4];
   logic       hs  [4];
   logic       vs  [4];
   logic       scr [4];
   logic       cmd [4];
   logic       fs  [4];

   string inst_name [4] = '{"d1", "d3", "s1", "s3"};
   string sig_name  [7] = '{"row", "col", "h_sync", "v_sync", "screen_inactive", "cmd_en", "frame_start"};

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   emern_scan_timing #(.PIPE_DELAY(1)) u_d1 (
      .clk(clk), .rst(rst), .row_counter(row[0]), .col_counter(col[0]), .h_sync(hs[0]),
      .v_sync(vs[0]), .screen_inactive(scr[0]), .cmd_en(cmd[0]), .frame_start(fs[0]));

   emern_scan_timing #(.PIPE_DELAY(3)) u_d3 (
      .clk(clk), .rst(rst), .row_counter(row[1]), .col_counter(col[1]), .h_sync(hs[1]),
      .v_sync(vs[1]), .screen_inactive(scr[1]), .cmd_en(cmd[1]), .frame_start(fs[1]));

   // Reduced geometry: 16 columns x 10 rows, 160-cycle frame
   emern_scan_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .PIPE_DELAY(1)) u_s1 (
      .clk(clk), .rst(rst), .row_counter(row[2]), .col_counter(col[2]), .h_sync(hs[2]),
      .v_sync(vs[2]), .screen_inactive(scr[2]), .cmd_en(cmd[2]), .frame_start(fs[2]));

   emern_scan_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .PIPE_DELAY(3)) u_s3 (
      .clk(clk), .rst(rst), .row_counter(row[3]), .col_counter(col[3]), .h_sync(hs[3]),
      .v_sync(vs[3]), .screen_inactive(scr[3]), .cmd_en(cmd[3]), .frame_start(fs[3]));

   function automatic logic [31:0] actual(int inst, int sig);
      case (sig)
         ROW:     return {22'b0, row[inst]};
         COL:     return {22'b0, col[inst]};
         HS:      return {31'b0, hs[inst]};
         VS:      return {31'b0, vs[inst]};
         SCR:     return {31'b0, scr[inst]};
         CMD:     return {31'b0, cmd[inst]};
         default: return {31'b0, fs[inst]};
      endcase
   endfunction

   task automatic ex(input int k, input int inst, input int sig, input int v);
      sb.push_back('{base + k, inst, sig, v});
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].t == tick) begin
            logic [31:0] a;
            a = actual(sb[i].inst, sb[i].sig);
            checks++;
            if (a !== 32'(sb[i].exp))
               $display("FAIL %s.%s @tick %0d: got %0d, want %0d", inst_name[sb[i].inst],
                        sig_name[sb[i].sig], tick, a, sb[i].exp);
            else
               passed++;
            sb.delete(i);
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      base = tick;

      checks++;
      if (row[0] !== 10'd0) $display("FAIL d1.row after release: got %0d, want 0", row[0]);
      else passed++;
      checks++;
      if (col[0] !== 10'd0) $display("FAIL d1.col after release: got %0d, want 0", col[0]);
      else passed++;
      checks++;
      if (hs[0] !== 1'b1) $display("FAIL d1.h_sync after release: got %0b, want 1", hs[0]);
      else passed++;
      checks++;
      if (vs[0] !== 1'b1) $display("FAIL d1.v_sync after release: got %0b, want 1", vs[0]);
      else passed++;
      checks++;
      if (scr[0] !== 1'b1) $display("FAIL d1.screen_inactive after release: got %0b, want 1", scr[0]);
      else passed++;
      checks++;
      if (cmd[0] !== 1'b0) $display("FAIL d1.cmd_en after release: got %0b, want 0", cmd[0]);
      else passed++;
      checks++;
      if (fs[0] !== 1'b0) $display("FAIL d1.frame_start after release: got %0b, want 0", fs[0]);
      else passed++;

      // Full-size timing, first line and start of second
      ex(0, D1, ROW, 0);  ex(0, D1, COL, 0);  ex(1, D1, COL, 1);  ex(2, D1, COL, 2);
      ex(0, D1, HS, 1);   ex(656, D1, HS, 1); ex(657, D1, HS, 0); ex(752, D1, HS, 0);
      ex(753, D1, HS, 1);
      ex(0, D1, SCR, 1);  ex(1, D1, SCR, 0);  ex(640, D1, SCR, 0); ex(641, D1, SCR, 1);
      ex(800, D1, SCR, 1); ex(801, D1, SCR, 0);
      ex(0, D1, VS, 1);   ex(801, D1, VS, 1); ex(0, D1, CMD, 0);  ex(801, D1, CMD, 0);
      ex(0, D1, FS, 0);   ex(800, D1, ROW, 1); ex(800, D1, COL, 0);
      ex(658, D3, HS, 1); ex(659, D3, HS, 0); ex(754, D3, HS, 0); ex(755, D3, HS, 1);
      ex(2, D3, SCR, 1);  ex(3, D3, SCR, 0);  ex(642, D3, SCR, 0); ex(643, D3, SCR, 1);
      ex(802, D3, SCR, 1); ex(803, D3, SCR, 0); ex(657, D3, COL, 657); ex(96, D3, CMD, 0);

      // Reduced geometry: vertical window, wrap and frame period
      ex(95, S1, CMD, 0);  ex(96, S1, CMD, 1);  ex(96, S1, ROW, 6);  ex(96, S1, COL, 0);
      ex(112, S1, VS, 1);  ex(113, S1, VS, 0);  ex(144, S1, VS, 0);  ex(145, S1, VS, 1);
      ex(159, S1, CMD, 1); ex(160, S1, CMD, 0); ex(159, S1, ROW, 9); ex(159, S1, COL, 15);
      ex(160, S1, ROW, 0); ex(160, S1, COL, 0);
      ex(0, S1, FS, 0);    ex(159, S1, FS, 0);  ex(160, S1, FS, 1);  ex(161, S1, FS, 0);
      ex(319, S1, FS, 0);  ex(320, S1, FS, 1);
      ex(10, S1, HS, 1);   ex(11, S1, HS, 0);   ex(13, S1, HS, 0);   ex(14, S1, HS, 1);
      ex(114, S3, VS, 1);  ex(115, S3, VS, 0);  ex(146, S3, VS, 0);  ex(147, S3, VS, 1);
      ex(96, S3, CMD, 1);  ex(160, S3, FS, 1);  ex(12, S3, HS, 1);   ex(13, S3, HS, 0);

      // Row 8, col 11 of the reduced frame: both syncs low when reset hits
      ex(939, S1, ROW, 8); ex(939, S1, COL, 11); ex(939, S1, HS, 0); ex(939, S1, VS, 0);
      for (int k = 940; k <= 944; k++) begin
         for (int n = 0; n < 4; n++) begin
            ex(k, n, ROW, 0); ex(k, n, COL, 0); ex(k, n, HS, 1); ex(k, n, VS, 1);
            ex(k, n, SCR, 1); ex(k, n, CMD, 0); ex(k, n, FS, 0);
         end
      end

      repeat (939) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      checks++;
      if (row[2] !== 10'd0 || col[2] !== 10'd0)
         $display("FAIL s1 counters during reset: got (%0d,%0d), want (0,0)", row[2], col[2]);
      else passed++;
      checks++;
      if (hs[2] !== 1'b1 || vs[2] !== 1'b1)
         $display("FAIL s1 syncs during reset: got hs=%0b vs=%0b, want 1,1", hs[2], vs[2]);
      else passed++;
      checks++;
      if (hs[1] !== 1'b1 || vs[1] !== 1'b1 || scr[1] !== 1'b1)
         $display("FAIL d3 delayed outputs during reset: got %0b%0b%0b, want 111", hs[1], vs[1], scr[1]);
      else passed++;
      checks++;
      if (cmd[3] !== 1'b0 || fs[3] !== 1'b0)
         $display("FAIL s3 cmd_en/frame_start during reset: got %0b,%0b, want 0,0", cmd[3], fs[3]);
      else passed++;

      rst = 1'b0;
      base = tick;

      // After release: clean restart, no sync low before its normal column
      ex(0, D1, COL, 0);   ex(1, D1, COL, 1);   ex(2, D1, COL, 2);
      ex(656, D1, HS, 1);  ex(657, D1, HS, 0);  ex(0, D1, FS, 0);
      for (int k = 0; k <= 10; k++) ex(k, S1, HS, 1);
      ex(11, S1, HS, 0);   ex(0, S1, VS, 1);    ex(112, S1, VS, 1);  ex(113, S1, VS, 0);

      repeat (905) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         checks++;
         $display("FAIL %s.%s never sampled (due tick %0d, want %0d)",
                  inst_name[sb[0].inst], sig_name[sb[0].sig], sb[0].t, sb[0].exp);
         sb.delete(0);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
